chess_turn_ctrl: RTL

Game-sequencing controller for the chess clock. It debounces the two player keys and the start key, and runs a four-state game machine. It issues single-cycle turn-set pulses and a 10 Hz count tick to the per-turn countdown timer, then latches the winner when that timer reports timeout. It also keeps per-player move counts for the display path.

---
 rtl/chess_turn_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/chess_turn_ctrl.sv
// Chess clock game sequencer: debounces the two player keys and the start key,
// runs the IDLE/RUN_A/RUN_B/OVER game machine, and drives the countdown timer
// with turn-set pulses and a divided count tick. Per-player move counts are
// kept for the display path.
module chess_turn_ctrl #(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned MOVE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_a,
  input  logic              key_b,
  input  logic              key_start,
  input  logic              timeout,
  output logic              tick,
  output logic              set_a,
  output logic              set_b,
  output logic [1:0]        state,
  output logic              winner_a,
  output logic              winner_b,
  output logic [MOVE_W-1:0] moves_a,
  output logic [MOVE_W-1:0] moves_b
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRunA = 2'b01,
    StRunB = 2'b10,
    StOver = 2'b11
  } state_e;

  localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned DivW = $clog2(TICK_DIV);

  localparam logic [DbW-1:0]    DbLast  = DbW'(DB_CYCLES - 1);
  localparam logic [DivW-1:0]   DivLast = DivW'(TICK_DIV - 1);
  localparam logic [MOVE_W-1:0] MoveMax = '1;

  // Channel order: bit 0 = key_a, bit 1 = key_b, bit 2 = key_start
  logic [2:0]          keys_raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          db_q, db_d;
  logic [2:0]          press_q, press_d;
  logic [2:0][DbW-1:0] cnt_q, cnt_d;

  logic pa, pb, ps;
  logic to_ok;

  state_e state_q, state_d;

  logic              set_a_q, set_a_d;
  logic              set_b_q, set_b_d;
  logic              set_dly_q, set_dly_d;
  logic              tick_q, tick_d;
  logic              winner_a_q, winner_a_d;
  logic              winner_b_q, winner_b_d;
  logic [MOVE_W-1:0] moves_a_q, moves_a_d;
  logic [MOVE_W-1:0] moves_b_q, moves_b_d;
  logic [DivW-1:0]   div_q, div_d;

  logic run_d;
  logic changed;

  assign keys_raw = {key_start, key_b, key_a};

  // Debounce: accept a new synchronised level after DB_CYCLES stable cycles
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      db_d[i]  = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DbLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DbW'(1);
        end
      end
    end
    press_d = db_d & ~db_q;
  end

  // Synchroniser, debounce counters, debounced levels and press events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pa = press_q[0];
  assign pb = press_q[1];
  assign ps = press_q[2];

  // Timeout is blanked during a set pulse and the cycle after it, so a stale
  // level from the previous turn cannot end the new one.
  assign to_ok = timeout & ~set_a_q & ~set_b_q & ~set_dly_q;

  // Game state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: timeout beats start/abort, which beats the own-key press
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (ps) state_d = StRunA;
      StRunA: begin
        if (to_ok)   state_d = StOver;
        else if (ps) state_d = StIdle;
        else if (pa) state_d = StRunB;
      end
      StRunB: begin
        if (to_ok)   state_d = StOver;
        else if (ps) state_d = StIdle;
        else if (pb) state_d = StRunA;
      end
      StOver: if (ps) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs derived from the transition being taken this cycle
  always_comb begin
    run_d   = (state_d == StRunA) || (state_d == StRunB);
    changed = (state_d != state_q);

    set_a_d   = (state_d == StRunA) && changed;
    set_b_d   = (state_d == StRunB) && changed;
    set_dly_d = set_a_q | set_b_q;

    // Divider restarts on every turn change and idles outside RUN states
    div_d  = '0;
    tick_d = 1'b0;
    if (run_d && !changed) begin
      if (div_q == DivLast) begin
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end

    winner_a_d = winner_a_q;
    winner_b_d = winner_b_q;
    moves_a_d  = moves_a_q;
    moves_b_d  = moves_b_q;

    if (changed) begin
      if (state_d == StIdle) begin
        winner_a_d = 1'b0;
        winner_b_d = 1'b0;
      end else if (state_q == StIdle) begin
        winner_a_d = 1'b0;
        winner_b_d = 1'b0;
        moves_a_d  = '0;
        moves_b_d  = '0;
      end else if (state_d == StOver) begin
        if (state_q == StRunA) winner_b_d = 1'b1;
        else                   winner_a_d = 1'b1;
      end else if (state_d == StRunB) begin
        if (moves_a_q != MoveMax) moves_a_d = moves_a_q + MOVE_W'(1);
      end else begin
        if (moves_b_q != MoveMax) moves_b_d = moves_b_q + MOVE_W'(1);
      end
    end
  end

  // Output and divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_a_q    <= 1'b0;
      set_b_q    <= 1'b0;
      set_dly_q  <= 1'b0;
      tick_q     <= 1'b0;
      winner_a_q <= 1'b0;
      winner_b_q <= 1'b0;
      moves_a_q  <= '0;
      moves_b_q  <= '0;
      div_q      <= '0;
    end else begin
      set_a_q    <= set_a_d;
      set_b_q    <= set_b_d;
      set_dly_q  <= set_dly_d;
      tick_q     <= tick_d;
      winner_a_q <= winner_a_d;
      winner_b_q <= winner_b_d;
      moves_a_q  <= moves_a_d;
      moves_b_q  <= moves_b_d;
      div_q      <= div_d;
    end
  end

  assign state    = state_q;
  assign tick     = tick_q;
  assign set_a    = set_a_q;
  assign set_b    = set_b_q;
  assign winner_a = winner_a_q;
  assign winner_b = winner_b_q;
  assign moves_a  = moves_a_q;
  assign moves_b  = moves_b_q;

endmodule
